sod_update_receiver: RTL
========================

Name: sod_update_receiver

Overview:
Receive-side counterpart of the 4-channel send-on-delta sample compressor. It accepts update strobes (channel id plus 8-bit value) from the compressor and keeps a reconstructed copy of each channel. It flags channels that have gone quiet for too long, and buffers update events in a small FIFO for a downstream consumer. It sits between the compressor's update output and the host/readout logic.

Parameters:
DATA_W, 8, sample width in bits.
STALE_CYCLES, 1000, cycles without an update before a channel is flagged stale; legal range 2..65535.
FIFO_DEPTH, 4, event FIFO entries; must be a power of 2, minimum 2.

Ports:
clk  input  1  clock; all logic on its rising edge.
rst_n  input  1  reset: synchronous, active-high (asserted = 1, despite the suffix).
upd_valid  input  1  single-cycle update strobe from the compressor.
upd_ch  input  2  channel index of the update.
upd_data  input  DATA_W  new channel value.
rd_ch  input  2  readout channel select.
rd_data  output  DATA_W  registered reconstructed value of rd_ch.
rd_stale  output  1  registered stale bit of rd_ch.
stale_mask  output  4  per-channel stale flags; bit n = channel n.
evt_valid  output  1  FIFO not empty (first-word fall-through).
evt_ch  output  2  channel of the head event.
evt_data  output  DATA_W  value of the head event.
evt_ready  input  1  consumer accepts the head event when evt_valid=1.
evt_overflow  output  1  sticky flag: an event was dropped because the FIFO was full.

Behaviour:
- Reset (rst_n=1 at a clock edge):
  - channel values = 0, rd_data = 0, timers = 0.
  - stale_mask = 4'b1111 (no update received yet); rd_stale = 1.
  - FIFO emptied, so evt_valid = 0; evt_ch and evt_data = 0.
  - evt_overflow = 0.
  - Reset mid-operation discards all FIFO contents and values on that edge.
- Update: when upd_valid=1 at an edge:
  - value[upd_ch] <= upd_data.
  - timer[upd_ch] <= 0.
  - stale_mask[upd_ch] <= 0.
  - An event {upd_ch, upd_data} is pushed to the FIFO.
- Stale timer, per channel:
  - While the stale bit is 0 and no update arrives, the timer increments by 1 each cycle.
  - When the timer equals STALE_CYCLES-1 and the channel gets no update that cycle, the stale bit <= 1 on that edge and the timer holds.
  - Net effect: stale is seen STALE_CYCLES cycles after the last update edge.
  - An update in the same cycle as expiry wins: stale stays 0 and the timer is cleared.
  - The timer does not count while stale; the next update restarts it from 0.
- Readout: rd_data <= value[rd_ch] and rd_stale <= stale_mask[rd_ch], with 1-cycle latency.
  - On an update to rd_ch in the same cycle, the readout shows the pre-update value and stale bit.
  - The new value is visible one cycle later.
- Event FIFO, FWFT:
  - evt_ch and evt_data always show the head entry while evt_valid=1.
  - Pop occurs when evt_valid & evt_ready.
  - Push when full with no pop in the same cycle: the event is dropped and evt_overflow <= 1. It stays set until reset.
  - Push and pop in the same cycle when full: both occur and the count is unchanged; no overflow.
  - Push and pop when empty: the push is stored; evt_valid rises the next cycle, since there is no bypass.
  - evt_ready while empty is ignored.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - Channel values and stale tracking update regardless of FIFO state.
- Arithmetic: timers are 16-bit unsigned and never wrap. FIFO count is log2(FIFO_DEPTH)+1 bits.

Test Plan:
- Reset then idle 5 cycles -> stale_mask=4'b1111, evt_valid=0, rd_data=0, rd_stale=1, evt_overflow=0.
- upd_valid with ch=2, data=8'h5A, evt_ready=0; rd_ch=2 -> next cycle: evt_valid=1, evt_ch=2, evt_data=8'h5A, stale_mask=4'b1011. Cycle after: rd_data=8'h5A, rd_stale=0.
- STALE_CYCLES=8; update ch0, then no updates -> stale_mask[0] rises exactly 8 cycles after the update edge. Repeat with an update to ch0 on cycle 8 -> stale stays 0.
- evt_ready=0; push 5 updates (ch0..3 then ch0, data 1..5) -> 4 entries held, evt_overflow=1. Drain with evt_ready=1 -> data 1,2,3,4 in order, then evt_valid=0.
- Fill the FIFO, then apply push (data 8'hAA) and evt_ready=1 in the same cycle -> the head pops, 8'hAA is stored at the tail, and evt_overflow stays 0.
- Assert rst_n with 3 events queued and ch1 updated -> next cycle: FIFO empty, value[1]=0, stale_mask=4'b1111.

Source files
------------

// File: rtl/sod_update_receiver.sv
// Receive side of the 4-channel send-on-delta link: rebuilds channel values,
// flags channels that have gone quiet, and queues update events for a consumer.
module sod_update_receiver #(
  parameter int DATA_W       = 8,
  parameter int STALE_CYCLES = 1000,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              upd_valid,
  input  logic [1:0]        upd_ch,
  input  logic [DATA_W-1:0] upd_data,
  input  logic [1:0]        rd_ch,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_stale,
  output logic [3:0]        stale_mask,
  output logic              evt_valid,
  output logic [1:0]        evt_ch,
  output logic [DATA_W-1:0] evt_data,
  input  logic              evt_ready,
  output logic              evt_overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = DATA_W + 2;
  localparam logic [15:0] STALE_TC = 16'(STALE_CYCLES - 1);

  logic [DATA_W-1:0] value_q [4];
  logic [DATA_W-1:0] value_d [4];
  logic [15:0]       timer_q [4];
  logic [15:0]       timer_d [4];
  logic [3:0]        stale_q, stale_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_stale_q, rd_stale_d;

  logic [EW-1:0]     mem_q [FIFO_DEPTH];
  logic [EW-1:0]     mem_d [FIFO_DEPTH];
  logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;

  logic              fifo_full, fifo_pop, fifo_push;
  logic [EW-1:0]     head;

  always_comb begin
    value_d = value_q;
    timer_d = timer_q;
    stale_d = stale_q;
    for (int i = 0; i < 4; i++) begin
      if (upd_valid && (upd_ch == 2'(i))) begin
        value_d[i] = upd_data;
        timer_d[i] = '0;
        stale_d[i] = 1'b0;
      end else if (!stale_q[i]) begin
        // Timer holds at terminal count once the channel goes stale.
        if (timer_q[i] == STALE_TC) stale_d[i] = 1'b1;
        else                        timer_d[i] = timer_q[i] + 16'd1;
      end
    end
    rd_data_d  = value_q[rd_ch];
    rd_stale_d = stale_q[rd_ch];
  end

  always_comb begin
    fifo_full = (count_q == CW'(FIFO_DEPTH));
    fifo_pop  = (count_q != '0) && evt_ready;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    fifo_push = upd_valid && (!fifo_full || fifo_pop);
    mem_d     = mem_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q | (upd_valid && fifo_full && !fifo_pop);
    if (fifo_push) begin
      mem_d[wptr_q] = {upd_ch, upd_data};
      wptr_d        = wptr_q + PW'(1);
    end
    if (fifo_pop) rptr_d = rptr_q + PW'(1);
    case ({fifo_push, fifo_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      value_q    <= '{default: '0};
      timer_q    <= '{default: '0};
      stale_q    <= 4'b1111;
      rd_data_q  <= '0;
      rd_stale_q <= 1'b1;
      mem_q      <= '{default: '0};
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      value_q    <= value_d;
      timer_q    <= timer_d;
      stale_q    <= stale_d;
      rd_data_q  <= rd_data_d;
      rd_stale_q <= rd_stale_d;
      mem_q      <= mem_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  assign head         = mem_q[rptr_q];
  assign evt_valid    = (count_q != '0);
  assign evt_ch       = evt_valid ? head[EW-1:DATA_W] : 2'b00;
  assign evt_data     = evt_valid ? head[DATA_W-1:0] : '0;
  assign evt_overflow = ovf_q;
  assign rd_data      = rd_data_q;
  assign rd_stale     = rd_stale_q;
  assign stale_mask   = stale_q;

endmodule
